// File: rtl/pcs_pkg.sv
// Shared constants and types for the Clause 49 64b/66b transmit encoder.
package pcs_pkg;

  localparam int BLOCK_N = 8;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] BT_IDLE  = 8'h1E;
  localparam logic [7:0] BT_START = 8'h78;

  localparam logic [6:0] CC_IDLE = 7'h00;
  localparam logic [6:0] CC_ERR  = 7'h1E;

  typedef enum logic {IDLE_S, FRAME_S} pcs_state_e;

  function automatic logic [7:0] term_type(input logic [2:0] len);
    logic [7:0] t;
    case (len)
      3'd0:    t = 8'h87;
      3'd1:    t = 8'h99;
      3'd2:    t = 8'hAA;
      3'd3:    t = 8'hB4;
      3'd4:    t = 8'hCC;
      3'd5:    t = 8'hD2;
      3'd6:    t = 8'hE1;
      default: t = 8'hFF;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pcs_tx_blk_enc.sv
// Combinational block encoder: one assembled 64-bit block plus its flags and
// the frame state in, one 66-bit block, error flag and next state out.
module pcs_tx_blk_enc
  import pcs_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic [63:0]      blk_data,
  input  logic             blk_start,
  input  logic             blk_idle,
  input  logic             blk_term,
  input  logic [LEN_W-1:0] term_len,
  input  logic             seq_err,
  input  pcs_state_e       state,
  output logic [65:0]      blk,
  output logic             err,
  output pcs_state_e       state_next
);

  logic        bad;
  logic [55:0] term_pl;

  always_comb begin
    // Lanes past the data bytes stay zero, which is exactly the /I/ code.
    term_pl = '0;
    for (int b = 0; b < BLOCK_N - 1; b++) begin
      if (b < int'(term_len)) term_pl[8*b +: 8] = blk_data[8*b +: 8];
    end
  end

  always_comb begin
    bad        = 1'b0;
    err        = 1'b0;
    state_next = state;
    blk        = {{BLOCK_N{CC_IDLE}}, BT_IDLE, SYNC_CTRL};
    case (state)
      IDLE_S: begin
        if (blk_start && !blk_term) begin
          blk        = {blk_data[63:8], BT_START, SYNC_CTRL};
          state_next = FRAME_S;
        end else if (blk_start || blk_term || !blk_idle) begin
          bad = 1'b1;
        end
      end
      FRAME_S: begin
        if (blk_term && !blk_start) begin
          blk        = {term_pl, term_type(term_len[2:0]), SYNC_CTRL};
          state_next = IDLE_S;
        end else if (blk_start || blk_idle) begin
          bad = 1'b1;
        end else begin
          blk = {blk_data, SYNC_DATA};
        end
      end
      default: bad = 1'b1;
    endcase
    if (seq_err || bad) begin
      blk        = {{BLOCK_N{CC_ERR}}, BT_IDLE, SYNC_CTRL};
      err        = 1'b1;
      state_next = IDLE_S;
    end
  end

endmodule

// File: rtl/pcs_tx_enc.sv
// 64b/66b transmit encoder: packs tx-pipe beats into 64-bit blocks, tracks
// per-block flags and beat-level violations, and registers the encoded block.
module pcs_tx_enc #(
  parameter int DATA_W      = 16,
  parameter int BLOCK_N     = 8,
  parameter int BLOCK_LEN_W = $clog2(BLOCK_N + 1),
  parameter int BEAT_N      = 64 / DATA_W
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   ctrl_v_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic                   start_i,
  input  logic                   idle_i,
  input  logic                   term_i,
  input  logic [BLOCK_LEN_W-1:0] term_len_i,
  input  logic                   pcs_ready_i,
  output logic                   ready_o,
  output logic                   blk_v_o,
  output logic [65:0]            blk_o,
  output logic                   err_o
);
  import pcs_pkg::*;

  localparam int CNT_W = (BEAT_N > 1) ? $clog2(BEAT_N) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEAT_N - 1);

  logic [CNT_W-1:0]       beat_cnt_reg;
  logic [63:0]            buf_reg;
  logic                   start_reg, idle_reg, term_reg, err_reg;
  logic [BLOCK_LEN_W-1:0] len_reg;
  pcs_state_e             state_reg, state_next;

  logic                   first_beat, last_beat, beat_err;
  logic                   cur_start, cur_idle, cur_term, cur_err;
  logic [BLOCK_LEN_W-1:0] cur_len;
  logic [63:0]            blk_data;
  logic [65:0]            enc_blk;
  logic                   enc_err;

  assign ready_o    = pcs_ready_i;
  assign first_beat = (beat_cnt_reg == '0);
  assign last_beat  = (beat_cnt_reg == LAST_BEAT);

  // The current beat is merged in combinationally so the last beat of a block
  // is encoded in the same cycle it is accepted.
  genvar gi;
  generate
    for (gi = 0; gi < BEAT_N; gi++) begin : g_lane
      assign blk_data[gi*DATA_W +: DATA_W] =
        (beat_cnt_reg == CNT_W'(gi)) ? data_i : buf_reg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    cur_start = first_beat ? start_i : start_reg;
    cur_idle  = first_beat ? idle_i  : idle_reg;
    cur_term  = term_reg | term_i;
    cur_len   = term_reg ? len_reg : term_len_i;
    beat_err  = (start_i && !first_beat)
             || (term_i && (term_len_i > BLOCK_LEN_W'(BLOCK_N - 1)))
             || ((start_i || term_i) && !ctrl_v_i)
             || (idle_i && !first_beat && !idle_reg);
    cur_err   = err_reg | beat_err;
  end

  pcs_tx_blk_enc #(.LEN_W(BLOCK_LEN_W)) u_blk_enc (
    .blk_data   (blk_data),
    .blk_start  (cur_start),
    .blk_idle   (cur_idle),
    .blk_term   (cur_term),
    .term_len   (cur_len),
    .seq_err    (cur_err),
    .state      (state_reg),
    .blk        (enc_blk),
    .err        (enc_err),
    .state_next (state_next)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      beat_cnt_reg <= '0;
      buf_reg      <= '0;
      start_reg    <= 1'b0;
      idle_reg     <= 1'b0;
      term_reg     <= 1'b0;
      err_reg      <= 1'b0;
      len_reg      <= '0;
      state_reg    <= IDLE_S;
      blk_v_o      <= 1'b0;
      blk_o        <= '0;
      err_o        <= 1'b0;
    end else begin
      blk_v_o <= 1'b0;
      err_o   <= 1'b0;
      if (pcs_ready_i) begin
        buf_reg <= blk_data;
        if (last_beat) begin
          beat_cnt_reg <= '0;
          start_reg    <= 1'b0;
          idle_reg     <= 1'b0;
          term_reg     <= 1'b0;
          err_reg      <= 1'b0;
          len_reg      <= '0;
          state_reg    <= state_next;
          blk_v_o      <= 1'b1;
          blk_o        <= enc_blk;
          err_o        <= enc_err;
        end else begin
          beat_cnt_reg <= beat_cnt_reg + 1'b1;
          start_reg    <= cur_start;
          idle_reg     <= cur_idle;
          term_reg     <= cur_term;
          err_reg      <= cur_err;
          len_reg      <= cur_len;
        end
      end
    end
  end

endmodule
